fifo_uart_tx: RTL and testbench

- Downstream consumer of the 8-bit synchronous FIFO.
- Pops one byte at a time while the FIFO is not empty and serialises it as an asynchronous UART frame on a single output line: start bit, 8 data bits LSB first, stop bit.
- Generates the FIFO read strobe itself, so the FIFO drains at line rate with no external control beyond an enable.

---
 rtl/fifo_uart_tx.sv | 190 +++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous FIFO and sends them as UART frames (start, DATA_W bits LSB first, [parity,] stop).
// Latency: POP, then LOAD, then the start bit; a frame lasts 2 + (DATA_W+2)*CLKS_PER_BIT cycles (+CLKS_PER_BIT with parity).
// Backpressure: a pop is issued only when tx_en=1 and empty=0. Define UART_TX_PARITY_EN to add an even parity bit.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              empty,
    input  logic [DATA_W-1:0] rd_data,
    output logic              RDEN,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    generate
        if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
            $error("fifo_uart_tx: CLKS_PER_BIT must be in 2..65535");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BAUD_W-1:0]   r_baud;
    logic [BAUD_W-1:0]   w_baud_nxt;
    logic [BIT_W-1:0]    r_bit;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic                r_tx;
    logic                r_rden;
    logic                r_busy;
    logic                r_done;
    logic                w_tx_nxt;
    logic                w_bit_end;
`ifdef UART_TX_PARITY_EN
    logic                r_parity;
    logic                w_parity_nxt;
`endif

    assign w_bit_end = (r_baud == BAUD_LAST);

    // Next-state, counters and shift register
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                if (tx_en && !empty) begin
                    w_state_nxt = S_POP;
                end
            end
            S_POP: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                // rd_data is valid now, one cycle after the read strobe
                w_shift_nxt = rd_data;
                w_baud_nxt  = '0;
`ifdef UART_TX_PARITY_EN
                w_parity_nxt = ^rd_data;
`endif
                w_state_nxt = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == BIT_LAST) begin
                        w_bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + BIT_ONE;
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_STOP;
                end else begin
                    w_baud_nxt = r_baud + BAUD_ONE;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = (tx_en && !empty) ? S_POP : S_IDLE;
                end else begin
                    w_baud_nxt = r_baud + BAUD_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Line level decoded from the next state so tx is registered yet aligned with r_state
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_nxt = w_parity_nxt;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_rden   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_tx     <= w_tx_nxt;
            r_rden   <= (w_state_nxt == S_POP);
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= (w_state_nxt == S_STOP) && (w_baud_nxt == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    assign tx      = r_tx;
    assign RDEN    = r_rden;
    assign busy    = r_busy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO model feeds the DUT, a monitor decodes the line against a queue of expected bytes.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = 2 + NB * CPB;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_en = 1'b0;
    logic       empty = 1'b1;
    logic [7:0] rd_data = 8'h00;
    logic       RDEN;
    logic       tx;
    logic       busy;
    logic       tx_done;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    chk_t       chk_q[$];
    int         rden_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int busy_cyc = 0;
    int done_cnt = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_en   (tx_en),
        .empty   (empty),
        .rd_data (rd_data),
        .RDEN    (RDEN),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears on rd_data the cycle after RDEN is sampled
    always @(posedge clk) begin
        if (RDEN && fifo_q.size() > 0) rd_data <= fifo_q.pop_front();
    end

    always @(negedge clk) empty = (fifo_q.size() == 0);

    // Monitor: scalar checks from the stimulus plus per-cycle frame decoding
    logic        mon_act = 1'b0;
    logic        mon_bad = 1'b0;
    logic        mon_unexp = 1'b0;
    int          mon_cnt = 0;
    logic [10:0] mon_bits = '0;
    logic [7:0]  mon_byte = '0;
    logic [7:0]  mon_exp = '0;

    always @(negedge clk) begin
        chk_t c;
        int   idx;
        cyc++;
        if (RDEN === 1'b1) rden_q.push_back(cyc);
        if (busy === 1'b1) busy_cyc++;
        if (tx_done === 1'b1) done_cnt++;

        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_vec++;
            if (c.act != c.exp) begin
                n_err++;
                $display("FAIL %s: got %0d, want %0d", c.name, c.act, c.exp);
            end
        end

        if (rst !== 1'b1) begin
            mon_act = 1'b0;
        end else if (!mon_act && tx === 1'b0) begin
            mon_act   = 1'b1;
            mon_cnt   = 0;
            mon_bad   = 1'b0;
            mon_byte  = '0;
            mon_unexp = (exp_q.size() == 0);
            mon_exp   = mon_unexp ? 8'h00 : exp_q[0];
`ifdef UART_TX_PARITY_EN
            mon_bits  = {1'b1, ^mon_exp, mon_exp, 1'b0};
`else
            mon_bits  = {1'b1, 1'b1, mon_exp, 1'b0};
`endif
        end

        if (mon_act) begin
            idx = mon_cnt / CPB;
            if (tx !== mon_bits[idx]) mon_bad = 1'b1;
            if ((tx_done === 1'b1) != (mon_cnt == NB * CPB - 1)) mon_bad = 1'b1;
            if (idx >= 1 && idx <= 8 && (mon_cnt % CPB) == CPB / 2) mon_byte[idx-1] = tx;
            if (mon_cnt == NB * CPB - 1) begin
                n_vec++;
                if (mon_bad || mon_unexp) begin
                    n_err++;
                    $display("FAIL frame: got byte %02h (timing/parity/stop ok=%0d), want %02h%s",
                             mon_byte, !mon_bad, mon_exp, mon_unexp ? " (no frame expected)" : "");
                end
                if (!mon_unexp) void'(exp_q.pop_front());
                mon_act = 1'b0;
            end
            mon_cnt++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        chk_q.push_back('{nm, act, exp});
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        @(negedge clk);
        while (busy !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_start_timeout"}, (t >= 50) ? 1 : 0, 0);
        t = 0;
        while ((busy !== 1'b0 || fifo_q.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_idle_timeout"}, (t >= 2000) ? 1 : 0, 0);
    endtask

    initial begin
        int b_r, b_busy, b_done, t, n_rden, n_txlo, n_busy;

        // Reset held with a byte already waiting
        tx_en = 1'b1;
        fifo_q.push_back(8'hA5);
        exp_q.push_back(8'hA5);
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            chk("rst_tx", tx, 1);
            chk("rst_rden", RDEN, 0);
            chk("rst_busy", busy, 0);
        end

        // Single byte 0xA5
        b_r = rden_q.size(); b_busy = busy_cyc; b_done = done_cnt;
        rst = 1'b1;
        wait_idle("single");
        chk("single_rden_pulses", rden_q.size() - b_r, 1);
        chk("single_busy_cycles", busy_cyc - b_busy, FL);
        chk("single_tx_done", done_cnt - b_done, 1);

        // Back-to-back 01,02,03
        b_r = rden_q.size(); b_done = done_cnt;
        @(posedge clk); #1;
        for (int i = 1; i <= 3; i++) begin
            fifo_q.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        wait_idle("b2b");
        chk("b2b_rden_pulses", rden_q.size() - b_r, 3);
        if (rden_q.size() - b_r >= 3) begin
            chk("b2b_gap1", rden_q[b_r+1] - rden_q[b_r], FL);
            chk("b2b_gap2", rden_q[b_r+2] - rden_q[b_r+1], FL);
        end
        chk("b2b_tx_done", done_cnt - b_done, 3);
        chk("b2b_idle_tx", tx, 1);

        // Empty guard
        n_rden = 0; n_txlo = 0; n_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (RDEN !== 1'b0) n_rden++;
            if (tx !== 1'b1) n_txlo++;
            if (busy !== 1'b0) n_busy++;
        end
        chk("empty_rden_high", n_rden, 0);
        chk("empty_tx_low", n_txlo, 0);
        chk("empty_busy_high", n_busy, 0);

        // Reset during third data bit of 0xFF; 0x3C must follow intact
        b_r = rden_q.size(); b_done = done_cnt;
        @(posedge clk); #1;
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h3C);
        exp_q.push_back(8'h3C);
        t = 0;
        @(negedge clk);
        while (tx !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("midrst_start_timeout", (t >= 50) ? 1 : 0, 0);
        repeat (13) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_rden", RDEN, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_idle("midrst");
        chk("midrst_rden_pulses", rden_q.size() - b_r, 2);
        chk("midrst_tx_done", done_cnt - b_done, 1);

`ifdef UART_TX_PARITY_EN
        // Parity: 0x07 -> 1, 0x03 -> 0
        b_r = rden_q.size();
        @(posedge clk); #1;
        fifo_q.push_back(8'h07); exp_q.push_back(8'h07);
        fifo_q.push_back(8'h03); exp_q.push_back(8'h03);
        wait_idle("parity");
        chk("parity_rden_pulses", rden_q.size() - b_r, 2);
        if (rden_q.size() - b_r >= 2) chk("parity_frame_len", rden_q[b_r+1] - rden_q[b_r], 46);
`endif

        repeat (4) @(negedge clk);
        chk("expected_frames_left", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
